// File: rtl/qm_scoreboard.sv
// qm_scoreboard: per-register write-pending scoreboard with decode stall and drain handshake
module qm_scoreboard #(
  parameter int MAX_PENDING = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] di_RS,
  input  logic [4:0] di_RT,
  input  logic [4:0] di_WA,
  input  logic       ci_UsesRS,
  input  logic       ci_UsesRT,
  input  logic       ci_WritesReg,
  input  logic       ci_Issue,
  input  logic [4:0] di_RetireWA,
  input  logic       ci_RetireValid,
  input  logic       ci_Drain,
  output logic       co_Stall,
  output logic       co_IssueAccept,
  output logic       co_Busy,
  output logic       co_Drained,
  output logic       co_Underflow
);
  typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;
  state_t state;
  logic [1:0] pend [32];
  logic [6:0] total;
  logic haz, block, inc, dec, uf_evt;
  always_comb begin
    haz = (ci_UsesRS & |pend[di_RS]) | (ci_UsesRT & |pend[di_RT]) |
          (ci_WritesReg & |di_WA & (pend[di_WA] == 2'(MAX_PENDING)));
    block = haz | (state != RUN) | ci_Drain;
    co_Stall = reset_n & ci_Issue & block;
    co_IssueAccept = reset_n & ci_Issue & ~block;
    co_Busy = |total;
    inc = co_IssueAccept & ci_WritesReg & |di_WA;
    dec = ci_RetireValid & |di_RetireWA & |pend[di_RetireWA];
    uf_evt = ci_RetireValid & |di_RetireWA & ~|pend[di_RetireWA];
  end
  // pend[0] is only ever reset, so register 0 always reads as idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) pend[i] <= '0;
      total <= '0;
      state <= RUN;
      co_Drained <= 1'b0;
      co_Underflow <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++)
        pend[i] <= pend[i] + 2'(inc && di_WA == 5'(i)) - 2'(dec && di_RetireWA == 5'(i));
      total <= total + 7'(inc) - 7'(dec);
      co_Underflow <= co_Underflow | uf_evt;
      case (state)
        RUN: state <= ci_Drain ? DRAIN : RUN;
        DRAIN: state <= !ci_Drain ? RUN : (total == 0) ? HOLD : DRAIN;
        default: state <= ci_Drain ? HOLD : RUN;
      endcase
      co_Drained <= ci_Drain & ((state == HOLD) | (state == DRAIN & total == 0));
    end
  end
endmodule

// File: tb/tb_qm_scoreboard.sv
// tb_qm_scoreboard: randomized and directed checks against a pending-count reference model
module tb_qm_scoreboard;
  localparam int MAXP = 3;
  logic clk = 0, reset_n = 0;
  logic [4:0] rs, rt, wa, ra;
  logic urs, urt, wr, iss, rv, drn;
  logic stall, accept, busy, drained, uf;
  int passed = 0, checks = 0;
  int m_pend [32];
  bit m_uf, m_run, m_held;

  qm_scoreboard #(.MAX_PENDING(MAXP)) dut (
    .clk(clk), .reset_n(reset_n), .di_RS(rs), .di_RT(rt), .di_WA(wa),
    .ci_UsesRS(urs), .ci_UsesRT(urt), .ci_WritesReg(wr), .ci_Issue(iss),
    .di_RetireWA(ra), .ci_RetireValid(rv), .ci_Drain(drn),
    .co_Stall(stall), .co_IssueAccept(accept), .co_Busy(busy),
    .co_Drained(drained), .co_Underflow(uf)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int m_sum();
    int s = 0;
    for (int i = 1; i < 32; i++) s += m_pend[i];
    return s;
  endfunction

  task automatic idle();
    {rs, rt, wa, ra} = '0;
    {urs, urt, wr, iss, rv} = '0;
  endtask

  // One clock: compare outputs with the model, then advance the model by the rules
  task automatic step();
    int s;
    bit haz, blk;
    s = m_sum();
    haz = (urs && m_pend[rs] != 0) || (urt && m_pend[rt] != 0) ||
          (wr && wa != 0 && m_pend[wa] == MAXP);
    blk = haz || !m_run || drn;
    #2;
    chk("stall", stall, iss && blk);
    chk("accept", accept, iss && !blk);
    chk("busy", busy, s != 0);
    chk("drained", drained, m_held);
    chk("underflow", uf, m_uf);
    @(posedge clk);
    if (rv && ra != 0) begin
      if (m_pend[ra] != 0) m_pend[ra]--;
      else m_uf = 1;
    end
    if (iss && !blk && wr && wa != 0) m_pend[wa]++;
    if (m_run) begin
      if (drn) m_run = 0;
    end else if (!drn) begin
      m_run = 1;
      m_held = 0;
    end else if (s == 0) m_held = 1;
    #1;
  endtask

  task automatic do_reset();
    idle();
    iss = 1;
    drn = 0;
    reset_n = 0;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_accept", accept, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drained", drained, 0);
    chk("rst_uf", uf, 0);
    @(posedge clk);
    #1 reset_n = 1;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_uf = 0;
    m_run = 1;
    m_held = 0;
  endtask

  task automatic issue_w(logic [4:0] a);
    idle();
    iss = 1; wr = 1; wa = a;
  endtask

  initial begin
    do_reset();
    step();
    // RAW hazard on r5, still stalled in the retire cycle
    issue_w(5); step();
    #1 chk("raw_busy", busy, 1);
    idle(); iss = 1; urs = 1; rs = 5; step();
    step();
    rv = 1; ra = 5;
    #1 chk("raw_retire_stall", stall, 1);
    step();
    rv = 0;
    #1 chk("raw_accept", accept, 1);
    step();
    // saturation on r7
    repeat (3) begin issue_w(7); step(); end
    issue_w(7);
    #1 chk("sat_stall", stall, 1);
    step();
    rv = 1; ra = 7; step();
    rv = 0;
    #1 chk("sat_accept", accept, 1);
    step();
    // same-cycle issue and retire on r3
    issue_w(3); step();
    issue_w(3); rv = 1; ra = 3; step();
    idle(); iss = 1; urt = 1; rt = 3;
    #1 chk("sim_pend_kept", stall, 1);
    step();
    idle(); rv = 1; ra = 3; step();
    repeat (3) begin idle(); rv = 1; ra = 7; step(); end
    issue_w(0); step();
    #1 chk("r0_not_busy", busy, 0);
    idle(); iss = 1; urt = 1; rt = 0; step();
    // drain to HOLD and release
    issue_w(10); step();
    issue_w(11); step();
    idle(); drn = 1; iss = 1; step();
    idle(); iss = 1; rv = 1; ra = 10; step();
    idle(); rv = 1; ra = 11; step();
    idle(); step();
    step();
    #1 chk("drained_set", drained, 1);
    iss = 1; step();
    drn = 0; step();
    #1 chk("drain_resume", accept, 1);
    step();
    // drain abandoned before it completes
    issue_w(12); step();
    idle(); drn = 1; repeat (3) step();
    drn = 0; repeat (2) step();
    rv = 1; ra = 12; step();
    // underflow is sticky
    idle(); rv = 1; ra = 9; step();
    idle(); rv = 1; ra = 0; step();
    issue_w(4); step();
    idle(); rv = 1; ra = 4; step();
    #1 chk("uf_sticky", uf, 1);
    do_reset();
    for (int n = 0; n < 800; n++) begin
      int c;
      idle();
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); wa = 5'($urandom_range(0, 7));
      urs = 1'($urandom); urt = 1'($urandom); wr = 1'($urandom);
      iss = ($urandom % 4) != 0;
      rv = ($urandom % 3) == 0;
      c = $urandom_range(0, 7);
      ra = 5'($urandom_range(0, 7));
      if ($urandom % 16 != 0)
        for (int j = 0; j < 8; j++)
          if (m_pend[(c + j) % 8] != 0) begin ra = 5'((c + j) % 8); break; end
      if ($urandom % 24 == 0) drn = !drn;
      step();
    end
    do_reset();
    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
